// File: rtl/perf_pkg.sv
// Shared definitions for the performance event counter: FSM state codes,
// counter slot indices and the number of counters.
package perf_pkg;

  typedef logic [1:0] perfState_t;

  localparam perfState_t ST_COUNT = 2'd0;
  localparam perfState_t ST_DUMP  = 2'd1;
  localparam perfState_t ST_DONE  = 2'd2;

  localparam int NUM_CNT = 6;

  localparam logic [2:0] IDX_CYC  = 3'd0;
  localparam logic [2:0] IDX_INST = 3'd1;
  localparam logic [2:0] IDX_DHIT = 3'd2;
  localparam logic [2:0] IDX_IHIT = 3'd3;
  localparam logic [2:0] IDX_DREQ = 3'd4;
  localparam logic [2:0] IDX_IREQ = 3'd5;

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating event counter: clears on rst or clr, otherwise counts
// each inc pulse and holds at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/perf_event_counter.sv
// Accumulates six performance counters until Halt, then streams them out in
// index order over a valid/ready port and parks in DONE until rst or clr.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             Halt,
  input  logic             DCacheHit,
  input  logic             ICacheHit,
  input  logic             DCacheReq,
  input  logic             ICacheReq,
  input  logic             clr,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             halted,
  output logic             dump_done
);

  perfState_t       state;
  logic [2:0]       dumpIdx;
  logic             countEn;
  logic [NUM_CNT-1:0] incVec;
  logic [CNT_W-1:0] cntQ [NUM_CNT];
  logic [CNT_W-1:0] dumpData;

  assign countEn = (state == ST_COUNT);

  // Strobes only count while in COUNT; clr suppression happens inside each counter.
  always_comb begin
    incVec           = '0;
    incVec[IDX_CYC]  = countEn;
    incVec[IDX_INST] = countEn && (Halt || RegWrite || MemWrite);
    incVec[IDX_DHIT] = countEn && DCacheHit;
    incVec[IDX_IHIT] = countEn && ICacheHit;
    incVec[IDX_DREQ] = countEn && DCacheReq;
    incVec[IDX_IREQ] = countEn && ICacheReq;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gCnt
    perf_sat_counter #(
      .CNT_W(CNT_W)
    ) uCnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(incVec[g]),
      .q  (cntQ[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= ST_COUNT;
      dumpIdx <= 3'd0;
    end else begin
      case (state)
        ST_COUNT: begin
          if (Halt) begin
            state   <= ST_DUMP;
            dumpIdx <= 3'd0;
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (dumpIdx == IDX_IREQ) begin
              state <= ST_DONE;
            end else begin
              dumpIdx <= dumpIdx + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state   <= ST_COUNT;
          dumpIdx <= 3'd0;
        end
      endcase
    end
  end

  // Readout is purely combinational from the frozen counters, so a stalled word never changes.
  always_comb begin
    dumpData = '0;
    if (state == ST_DUMP) begin
      case (dumpIdx)
        IDX_CYC:  dumpData = cntQ[0];
        IDX_INST: dumpData = cntQ[1];
        IDX_DHIT: dumpData = cntQ[2];
        IDX_IHIT: dumpData = cntQ[3];
        IDX_DREQ: dumpData = cntQ[4];
        IDX_IREQ: dumpData = cntQ[5];
        default:  dumpData = '0;
      endcase
    end
  end

  assign dump_valid = (state == ST_DUMP);
  assign dump_idx   = dumpIdx;
  assign dump_data  = dumpData;
  assign halted     = (state == ST_DUMP) || (state == ST_DONE);
  assign dump_done  = (state == ST_DONE);

endmodule
